// File: rtl/mem_bus_responder.sv
// Single-port word memory behind a strobe/ready bus with a fixed, parameterised response latency.
// Requests are latched on acceptance; the read, write and error result are all committed on the edge entering RESP.
module mem_bus_responder #(
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_a,
    input  logic [31:0] m_din,
    output logic [31:0] m_dout,
    input  logic        m_strobe,
    input  logic [3:0]  m_wen,
    input  logic [1:0]  m_size,
    input  logic        m_rw,
    output logic        m_ready,
    output logic        m_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] din_q, din_d;
    logic [3:0]  wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic        rw_q, rw_d;
    logic [31:0] dout_q, dout_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem [2**AW];

    // With LATENCY=0 the response is committed on the acceptance edge, so
    // the datapath works on the live inputs in IDLE and the latched copy otherwise.
    logic [31:0] eff_a, eff_din;
    logic [3:0]  eff_wen;
    logic [1:0]  eff_size;
    logic        eff_rw;
    logic [AW-1:0] idx;
    logic        bad;
    logic        go;
    logic        mem_we;
    logic        unused_hi;

    assign eff_a     = (state_q == IDLE) ? m_a    : a_q;
    assign eff_din   = (state_q == IDLE) ? m_din  : din_q;
    assign eff_wen   = (state_q == IDLE) ? m_wen  : wen_q;
    assign eff_size  = (state_q == IDLE) ? m_size : size_q;
    assign eff_rw    = (state_q == IDLE) ? m_rw   : rw_q;
    assign idx       = eff_a[AW+1:2];
    assign unused_hi = ^eff_a[31:AW+2];

    always_comb begin
        bad = 1'b0;
        case (eff_size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = eff_a[0];
            2'b10:   bad = (eff_a[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        din_d   = din_q;
        wen_d   = wen_q;
        size_d  = size_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        go      = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_strobe) begin
                    a_d    = m_a;
                    din_d  = m_din;
                    wen_d  = m_wen;
                    size_d = m_size;
                    rw_d   = m_rw;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        go      = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (go) begin
            ready_d = 1'b1;
            err_d   = bad;
            dout_d  = bad ? 32'h0 : mem[idx];
            mem_we  = !bad && eff_rw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'h0;
            din_q   <= 32'h0;
            wen_q   <= 4'h0;
            size_q  <= 2'b00;
            rw_q    <= 1'b0;
            dout_q  <= 32'h0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            din_q   <= din_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Memory has no reset; a reset edge only suppresses the pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_wen[b]) mem[idx][8*b +: 8] <= eff_din[8*b +: 8];
            end
        end
    end

    assign m_dout  = dout_q;
    assign m_ready = ready_q;
    assign m_err   = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench: drivers push expected responses, per-instance monitors pop and compare on m_ready.
// Two instances cover LATENCY=2 (most scenarios) and LATENCY=0 (back-to-back strobe).
module tb_mem_bus_responder;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        logic        chk;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    exp_t q2[$];
    exp_t q0[$];

    logic [31:0] a2 = '0, din2 = '0, dout2;
    logic [3:0]  wen2 = '0;
    logic [1:0]  size2 = '0;
    logic        stb2 = 1'b0, rw2 = 1'b0, rdy2, err2;

    logic [31:0] a0 = '0, din0 = '0, dout0;
    logic [3:0]  wen0 = '0;
    logic [1:0]  size0 = '0;
    logic        stb0 = 1'b0, rw0 = 1'b0, rdy0, err0;

    mem_bus_responder #(.AW(10), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .m_a(a2), .m_din(din2), .m_dout(dout2), .m_strobe(stb2),
        .m_wen(wen2), .m_size(size2), .m_rw(rw2), .m_ready(rdy2), .m_err(err2)
    );

    mem_bus_responder #(.AW(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .m_a(a0), .m_din(din0), .m_dout(dout0), .m_strobe(stb0),
        .m_wen(wen0), .m_size(size0), .m_rw(rw0), .m_ready(rdy0), .m_err(err0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor(input string tag, input logic rdy, input logic err,
                           input logic [31:0] dout, inout exp_t q[$]);
        exp_t e;
        if (rdy) begin
            if (q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL %s_unexpected_ready: got ready at cycle %0d want none", tag, cyc);
            end else begin
                e = q.pop_front();
                chk({tag, "_ready_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({tag, "_err"}, {31'h0, err}, {31'h0, e.err});
                if (e.chk) chk({tag, "_dout"}, dout, e.dout);
            end
        end else if (err) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_err_without_ready: got err=1 want 0 (cycle %0d)", tag, cyc);
        end
    endtask

    always @(negedge clk) begin
        monitor("L2", rdy2, err2, dout2, q2);
        monitor("L0", rdy0, err0, dout0, q0);
    end

    // Issue one LATENCY=2 request at a negedge, scramble inputs after acceptance,
    // and return in the first IDLE cycle after the response.
    task automatic req2(input logic [31:0] a, input logic [31:0] din, input logic [3:0] wen,
                        input logic [1:0] size, input logic rw,
                        input logic [31:0] edout, input logic eerr, input logic echk);
        exp_t e;
        e.dout = edout; e.err = eerr; e.chk = echk; e.cyc = cyc + 3;
        q2.push_back(e);
        a2 = a; din2 = din; wen2 = wen; size2 = size; rw2 = rw; stb2 = 1'b1;
        @(negedge clk);
        stb2 = 1'b0;
        a2 = $urandom; din2 = $urandom; wen2 = 4'($urandom); size2 = 2'($urandom); rw2 = 1'($urandom);
        repeat (3) @(negedge clk);
    endtask

    task automatic req0(input logic [31:0] a, input logic [31:0] din, input logic rw,
                        input logic [31:0] edout, input logic echk);
        exp_t e;
        e.dout = edout; e.err = 1'b0; e.chk = echk; e.cyc = cyc + 1;
        q0.push_back(e);
        a0 = a; din0 = din; wen0 = 4'hF; size0 = 2'b10; rw0 = rw; stb0 = 1'b1;
        @(negedge clk);
        stb0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        chk("reset_ready2", {31'h0, rdy2}, 32'h0);
        chk("reset_err2",   {31'h0, err2}, 32'h0);
        chk("reset_dout2",  dout2, 32'h0);
        chk("reset_ready0", {31'h0, rdy0}, 32'h0);
        chk("reset_dout0",  dout0, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // LATENCY=0: preload then three back-to-back reads with strobe held high
        req0(32'h40, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            e.dout = 32'hCAFEF00D; e.err = 1'b0; e.chk = 1'b1; e.cyc = cyc + 1 + 2*i;
            q0.push_back(e);
        end
        a0 = 32'h40; rw0 = 1'b0; size0 = 2'b10; stb0 = 1'b1;
        repeat (5) @(negedge clk);
        stb0 = 1'b0;
        repeat (2) @(negedge clk);

        // LATENCY=2 basic write/read, byte lanes, hold
        req2(32'h100, 32'hDEADBEEF, 4'hF, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0);
        req2(32'h100, 32'h0,        4'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
        req2(32'h100, 32'h11223344, 4'hF, 2'b10, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        req2(32'h102, 32'hAABBCCDD, 4'h4, 2'b00, 1'b1, 32'h11223344, 1'b0, 1'b1);
        req2(32'h100, 32'h0,        4'h0, 2'b10, 1'b0, 32'h11BB3344, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("dout_hold", dout2, 32'h11BB3344);

        // errors and alignment
        req2(32'h101, 32'hFFFFFFFF, 4'hF, 2'b10, 1'b1, 32'h0, 1'b1, 1'b1);
        req2(32'h100, 32'h0,        4'h0, 2'b10, 1'b0, 32'h11BB3344, 1'b0, 1'b1);
        req2(32'h100, 32'h0,        4'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1'b1);
        req2(32'h102, 32'h0,        4'h0, 2'b01, 1'b0, 32'h11BB3344, 1'b0, 1'b1);
        req2(32'h101, 32'h0,        4'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1'b1);
        req2(32'h103, 32'h0,        4'h0, 2'b00, 1'b0, 32'h11BB3344, 1'b0, 1'b1);

        // no-op write, alias
        req2(32'h100, 32'h0,        4'h0, 2'b10, 1'b1, 32'h11BB3344, 1'b0, 1'b1);
        req2(32'h100, 32'h0,        4'h0, 2'b10, 1'b0, 32'h11BB3344, 1'b0, 1'b1);
        req2(32'h4,    32'h5A5A5A5A, 4'hF, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0);
        req2(32'h1004, 32'h0,        4'h0, 2'b10, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1);

        // reset in WAIT aborts the write
        req2(32'h200, 32'h01020304, 4'hF, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0);
        a2 = 32'h200; din2 = 32'hFFFFFFFF; wen2 = 4'hF; size2 = 2'b10; rw2 = 1'b1; stb2 = 1'b1;
        @(negedge clk);
        stb2 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_wait_dout", dout2, 32'h0);
        repeat (3) @(negedge clk);
        req2(32'h200, 32'h0, 4'h0, 2'b10, 1'b0, 32'h01020304, 1'b0, 1'b1);

        // strobe together with reset is not accepted
        a2 = 32'h200; rw2 = 1'b0; size2 = 2'b10; stb2 = 1'b1; rst = 1'b1;
        @(negedge clk);
        stb2 = 1'b0; rst = 1'b0;
        repeat (5) @(negedge clk);
        req2(32'h200, 32'h0, 4'h0, 2'b10, 1'b0, 32'h01020304, 1'b0, 1'b1);

        for (int i = 0; i < 20 && (q2.size() != 0 || q0.size() != 0); i++) @(negedge clk);
        if (q2.size() != 0 || q0.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL missing_response: got %0d outstanding want 0", q2.size() + q0.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
